// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//
// Sequences one single-port unified memory that is shared by the core's
// instruction-fetch port and its load/store data port. Each access is
// arbitrated, the winner's address/data are latched and held on the memory
// for WAIT_CYCLES cycles, and the result is returned with a one-cycle
// rvalid pulse to the owning port. This block is the stall source for
// multi-cycle memory operation.
//
// Parameters:
//   AW           address width
//   DW           data width
//   WAIT_CYCLES  memory access cycles per transfer (1..15)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, conflicts alternate between the two
//                       requesters; when undefined, data always beats fetch
//                       and no pointer register exists.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request and address
//   if_gnt                   fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata       fetch data return (one-cycle pulse)
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_gnt                    data accepted this cycle (combinational)
//   d_rvalid/d_rdata         load data / store completion (one-cycle pulse)
//   mem_en/mem_we/mem_addr/mem_wdata  memory macro controls (0 when idle)
//   mem_rdata                memory read data, valid in last mem_en cycle
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t          state_r;
   state_t          state_s;
   logic [3:0]      cnt_r;
   logic            owner_d_r;     // 1 = data port owns the transfer
   logic            mem_en_r;
   logic            mem_we_r;
   logic [AW-1:0]   mem_addr_r;
   logic [DW-1:0]   mem_wdata_r;
   logic            if_rvalid_r;
   logic            d_rvalid_r;
   logic [DW-1:0]   if_rdata_r;
   logic [DW-1:0]   d_rdata_r;

   logic            arb_window_s;
   logic            grant_d_s;
   logic            grant_if_s;
   logic            grant_any_s;
   logic            done_s;        // last BUSY cycle: capture read data

`ifdef ARB_ROUND_ROBIN_EN
   logic            last_d_r;      // 1 = data was granted last; reset points at fetch

   // Round-robin winner selection: on conflict, the port not granted last wins
   always_comb begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
      if (arb_window_s) begin
         grant_d_s  = d_req & (~if_req | ~last_d_r);
         grant_if_s = if_req & ~grant_d_s;
      end else begin
         grant_d_s  = 1'b0;
         grant_if_s = 1'b0;
      end
   end

   // Pointer follows every grant, conflicted or not
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d_r <= 1'b0;
      end else if (grant_any_s) begin
         last_d_r <= grant_d_s;
      end else begin
         last_d_r <= last_d_r;
      end
   end
`else
   // Fixed-priority winner selection: data always beats fetch
   always_comb begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
      if (arb_window_s) begin
         grant_d_s  = d_req;
         grant_if_s = if_req & ~d_req;
      end else begin
         grant_d_s  = 1'b0;
         grant_if_s = 1'b0;
      end
   end
`endif

   assign arb_window_s = (state_r == ST_IDLE) || (state_r == ST_RESP);
   assign grant_any_s  = grant_d_s | grant_if_s;
   assign done_s       = (state_r == ST_BUSY) && (cnt_r == 4'd0);

   // Next-state logic for the IDLE/BUSY/RESP sequencer
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_any_s) begin
               state_s = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == 4'd0) begin
               state_s = ST_RESP;
            end else begin
               state_s = ST_BUSY;
            end
         end
         ST_RESP: begin
            if (grant_any_s) begin
               state_s = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Transfer latches double as the registered memory outputs; cleared when
   // the transfer leaves BUSY so the macro sees zeros while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_d_r   <= 1'b0;
         cnt_r       <= 4'd0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else if (grant_any_s) begin
         owner_d_r   <= grant_d_s;
         cnt_r       <= CNT_LOAD;
         mem_en_r    <= 1'b1;
         mem_we_r    <= grant_d_s & d_we;
         mem_addr_r  <= grant_d_s ? d_addr : if_addr;
         mem_wdata_r <= grant_d_s ? d_wdata : '0;
      end else if (done_s) begin
         owner_d_r   <= owner_d_r;
         cnt_r       <= 4'd0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else if (state_r == ST_BUSY) begin
         owner_d_r   <= owner_d_r;
         cnt_r       <= cnt_r - 4'd1;
         mem_en_r    <= mem_en_r;
         mem_we_r    <= mem_we_r;
         mem_addr_r  <= mem_addr_r;
         mem_wdata_r <= mem_wdata_r;
      end else begin
         owner_d_r   <= owner_d_r;
         cnt_r       <= cnt_r;
         mem_en_r    <= mem_en_r;
         mem_we_r    <= mem_we_r;
         mem_addr_r  <= mem_addr_r;
         mem_wdata_r <= mem_wdata_r;
      end
   end

   // Read-data capture and rvalid pulse generation (pulse lands in RESP)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_rvalid_r <= 1'b0;
         d_rvalid_r  <= 1'b0;
         if_rdata_r  <= '0;
         d_rdata_r   <= '0;
      end else begin
         if_rvalid_r <= done_s & ~owner_d_r;
         d_rvalid_r  <= done_s & owner_d_r;
         if (done_s && owner_d_r) begin
            d_rdata_r <= mem_we_r ? '0 : mem_rdata;
         end else begin
            d_rdata_r <= d_rdata_r;
         end
         if (done_s && !owner_d_r) begin
            if_rdata_r <= mem_rdata;
         end else begin
            if_rdata_r <= if_rdata_r;
         end
      end
   end

   assign if_gnt    = grant_if_s;
   assign d_gnt     = grant_d_s;
   assign if_rvalid = if_rvalid_r;
   assign d_rvalid  = d_rvalid_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//
// Directed bench for shared_mem_arbiter. Two instances: u_w2 (WAIT_CYCLES=2)
// carries the fetch, conflict and reset scenarios; u_w1 (WAIT_CYCLES=1)
// carries the load/store scenario. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, so combinational grants reflect the
// inputs of the current cycle and registered outputs reflect the last rise.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

   logic        clk;
   logic        rst;

   // u_w2 stimulus / observation
   logic        w2_if_req;
   logic [31:0] w2_if_addr;
   logic        w2_if_gnt;
   logic        w2_if_rvalid;
   logic [31:0] w2_if_rdata;
   logic        w2_d_req;
   logic        w2_d_we;
   logic [31:0] w2_d_addr;
   logic [31:0] w2_d_wdata;
   logic        w2_d_gnt;
   logic        w2_d_rvalid;
   logic [31:0] w2_d_rdata;
   logic        w2_mem_en;
   logic        w2_mem_we;
   logic [31:0] w2_mem_addr;
   logic [31:0] w2_mem_wdata;
   logic [31:0] w2_mem_rdata;

   // u_w1 stimulus / observation
   logic        w1_if_req;
   logic [31:0] w1_if_addr;
   logic        w1_if_gnt;
   logic        w1_if_rvalid;
   logic [31:0] w1_if_rdata;
   logic        w1_d_req;
   logic        w1_d_we;
   logic [31:0] w1_d_addr;
   logic [31:0] w1_d_wdata;
   logic        w1_d_gnt;
   logic        w1_d_rvalid;
   logic [31:0] w1_d_rdata;
   logic        w1_mem_en;
   logic        w1_mem_we;
   logic [31:0] w1_mem_addr;
   logic [31:0] w1_mem_wdata;
   logic [31:0] w1_mem_rdata;

   int n_vec;
   int n_err;

   shared_mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rst(rst),
      .if_req(w2_if_req), .if_addr(w2_if_addr), .if_gnt(w2_if_gnt),
      .if_rvalid(w2_if_rvalid), .if_rdata(w2_if_rdata),
      .d_req(w2_d_req), .d_we(w2_d_we), .d_addr(w2_d_addr), .d_wdata(w2_d_wdata),
      .d_gnt(w2_d_gnt), .d_rvalid(w2_d_rvalid), .d_rdata(w2_d_rdata),
      .mem_en(w2_mem_en), .mem_we(w2_mem_we), .mem_addr(w2_mem_addr),
      .mem_wdata(w2_mem_wdata), .mem_rdata(w2_mem_rdata)
   );

   shared_mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst),
      .if_req(w1_if_req), .if_addr(w1_if_addr), .if_gnt(w1_if_gnt),
      .if_rvalid(w1_if_rvalid), .if_rdata(w1_if_rdata),
      .d_req(w1_d_req), .d_we(w1_d_we), .d_addr(w1_d_addr), .d_wdata(w1_d_wdata),
      .d_gnt(w1_d_gnt), .d_rvalid(w1_d_rvalid), .d_rdata(w1_d_rdata),
      .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr),
      .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // advance to the next falling edge (drive point of the next cycle)
   task automatic nxt();
      @(negedge clk);
   endtask

   logic exp_d [4];
   logic other_d;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      w2_if_req = 1'b0; w2_if_addr = 32'h0; w2_d_req = 1'b0; w2_d_we = 1'b0;
      w2_d_addr = 32'h0; w2_d_wdata = 32'h0; w2_mem_rdata = 32'h0;
      w1_if_req = 1'b0; w1_if_addr = 32'h0; w1_d_req = 1'b0; w1_d_we = 1'b0;
      w1_d_addr = 32'h0; w1_d_wdata = 32'h0; w1_mem_rdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
      exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif

      // ---------------- reset state
      nxt(); nxt(); #1;
      chk("rst_mem_en",    {31'd0, w2_mem_en},    32'd0);
      chk("rst_mem_we",    {31'd0, w2_mem_we},    32'd0);
      chk("rst_mem_addr",  w2_mem_addr,           32'd0);
      chk("rst_mem_wdata", w2_mem_wdata,          32'd0);
      chk("rst_if_rvalid", {31'd0, w2_if_rvalid}, 32'd0);
      chk("rst_d_rvalid",  {31'd0, w2_d_rvalid},  32'd0);
      chk("rst_if_rdata",  w2_if_rdata,           32'd0);
      chk("rst_d_rdata",   w2_d_rdata,            32'd0);
      nxt(); rst = 1'b0;

      // ---------------- single fetch, WAIT_CYCLES=2
      nxt(); w2_if_req = 1'b1; w2_if_addr = 32'h0000_0010; #1;   // T
      chk("f_if_gnt_T",  {31'd0, w2_if_gnt}, 32'd1);
      chk("f_d_gnt_T",   {31'd0, w2_d_gnt},  32'd0);
      chk("f_mem_en_T",  {31'd0, w2_mem_en}, 32'd0);
      nxt(); w2_if_req = 1'b0; #1;                               // T+1
      chk("f_mem_en_T1",   {31'd0, w2_mem_en}, 32'd1);
      chk("f_mem_addr_T1", w2_mem_addr,        32'h0000_0010);
      chk("f_mem_we_T1",   {31'd0, w2_mem_we}, 32'd0);
      chk("f_gnt_busy",    {31'd0, w2_if_gnt}, 32'd0);
      nxt(); w2_mem_rdata = 32'h0050_0093; #1;                   // T+2
      chk("f_mem_en_T2",   {31'd0, w2_mem_en}, 32'd1);
      nxt(); w2_mem_rdata = 32'hFFFF_FFFF; #1;                   // T+3
      chk("f_if_rvalid_T3", {31'd0, w2_if_rvalid}, 32'd1);
      chk("f_if_rdata_T3",  w2_if_rdata,           32'h0050_0093);
      chk("f_d_rvalid_T3",  {31'd0, w2_d_rvalid},  32'd0);
      chk("f_mem_en_T3",    {31'd0, w2_mem_en},    32'd0);
      chk("f_mem_addr_T3",  w2_mem_addr,           32'd0);
      nxt(); #1;                                                 // T+4
      chk("f_if_rvalid_T4", {31'd0, w2_if_rvalid}, 32'd0);
      chk("f_if_rdata_hold", w2_if_rdata,          32'h0050_0093);

      // ---------------- load then store, WAIT_CYCLES=1
      nxt(); w1_d_req = 1'b1; w1_d_we = 1'b0; w1_d_addr = 32'h0000_0044; #1;
      chk("ld_d_gnt", {31'd0, w1_d_gnt}, 32'd1);
      nxt(); w1_d_req = 1'b0; w1_mem_rdata = 32'hCAFE_F00D; #1;
      chk("ld_mem_en", {31'd0, w1_mem_en}, 32'd1);
      nxt(); w1_mem_rdata = 32'h0; #1;
      chk("ld_d_rvalid", {31'd0, w1_d_rvalid}, 32'd1);
      chk("ld_d_rdata",  w1_d_rdata,           32'hCAFE_F00D);

      nxt(); w1_d_req = 1'b1; w1_d_we = 1'b1; w1_d_addr = 32'h0000_0040;
      w1_d_wdata = 32'hDEAD_BEEF; #1;                            // T
      chk("st_d_gnt", {31'd0, w1_d_gnt}, 32'd1);
      nxt(); w1_d_req = 1'b0; w1_d_we = 1'b0; w1_mem_rdata = 32'h1234_5678; #1; // T+1
      chk("st_mem_en",    {31'd0, w1_mem_en}, 32'd1);
      chk("st_mem_we",    {31'd0, w1_mem_we}, 32'd1);
      chk("st_mem_addr",  w1_mem_addr,        32'h0000_0040);
      chk("st_mem_wdata", w1_mem_wdata,       32'hDEAD_BEEF);
      nxt(); #1;                                                 // T+2
      chk("st_d_rvalid",  {31'd0, w1_d_rvalid},  32'd1);
      chk("st_d_rdata",   w1_d_rdata,            32'd0);
      chk("st_if_rvalid", {31'd0, w1_if_rvalid}, 32'd0);
      chk("st_mem_we_off", {31'd0, w1_mem_we},   32'd0);

      // ---------------- conflict, both held high, WAIT_CYCLES=2
      nxt(); nxt();
      w2_if_req = 1'b1; w2_if_addr = 32'h0000_0020;
      w2_d_req = 1'b1; w2_d_we = 1'b0; w2_d_addr = 32'h0000_0080; #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("cf_d_gnt_%0d", k),  {31'd0, w2_d_gnt},  {31'd0, exp_d[k]});
         chk($sformatf("cf_if_gnt_%0d", k), {31'd0, w2_if_gnt}, {31'd0, ~exp_d[k]});
         if (k > 0) begin
            chk($sformatf("cf_d_rvalid_%0d", k), {31'd0, w2_d_rvalid}, {31'd0, exp_d[k-1]});
         end
         nxt();
         if (k == 3) begin
            if (exp_d[3]) w2_d_req = 1'b0;
            else          w2_if_req = 1'b0;
         end
         #1;
         chk($sformatf("cf_busy_gnt_%0d", k), {30'd0, w2_d_gnt, w2_if_gnt}, 32'd0);
         nxt(); nxt(); #1;                                       // next RESP
      end
      other_d = ~exp_d[3];
      chk("cf_last_d_gnt",  {31'd0, w2_d_gnt},  {31'd0, other_d});
      chk("cf_last_if_gnt", {31'd0, w2_if_gnt}, {31'd0, ~other_d});
      nxt(); w2_d_req = 1'b0; w2_if_req = 1'b0;
      nxt(); nxt(); #1;
      chk("cf_last_d_rvalid",  {31'd0, w2_d_rvalid},  {31'd0, other_d});
      chk("cf_last_if_rvalid", {31'd0, w2_if_rvalid}, {31'd0, ~other_d});
      nxt(); #1;
      chk("cf_idle_mem_en", {31'd0, w2_mem_en}, 32'd0);

      // ---------------- reset in the first BUSY cycle of a load
      nxt(); w2_d_req = 1'b1; w2_d_we = 1'b0; w2_d_addr = 32'h0000_0100;
      w2_mem_rdata = 32'h5555_AAAA; #1;
      chk("rs_d_gnt", {31'd0, w2_d_gnt}, 32'd1);
      nxt(); w2_d_req = 1'b0; #1;
      chk("rs_mem_en_before", {31'd0, w2_mem_en}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rs_mem_en_async",   {31'd0, w2_mem_en}, 32'd0);
      chk("rs_mem_addr_async", w2_mem_addr,        32'd0);
      nxt(); rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         nxt(); #1;
         chk($sformatf("rs_no_rvalid_%0d", c), {31'd0, w2_d_rvalid}, 32'd0);
         chk($sformatf("rs_no_mem_en_%0d", c), {31'd0, w2_mem_en},   32'd0);
      end
      nxt(); w2_d_req = 1'b1; w2_d_addr = 32'h0000_0104; #1;
      chk("rs2_d_gnt", {31'd0, w2_d_gnt}, 32'd1);
      nxt(); w2_d_req = 1'b0; #1;
      chk("rs2_mem_addr", w2_mem_addr, 32'h0000_0104);
      nxt(); w2_mem_rdata = 32'h0BAD_F00D; #1;
      nxt(); #1;
      chk("rs2_d_rvalid", {31'd0, w2_d_rvalid}, 32'd1);
      chk("rs2_d_rdata",  w2_d_rdata,           32'h0BAD_F00D);

      nxt();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
